// File: rtl/divider_pkg.sv
// Shared encodings for the multi-cycle restoring divider: FSM states, handshake levels, reset level.
// Also holds the latched-sign record used by the final sign correction.
package divider_pkg;

    localparam logic [1:0] DIV_FREE    = 2'b00;
    localparam logic [1:0] DIV_BY_ZERO = 2'b01;
    localparam logic [1:0] DIV_ON      = 2'b10;
    localparam logic [1:0] DIV_END     = 2'b11;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic RST_ENABLE           = 1'b1;

    // Width of the {HI, LO} result bus returned to execute.
    localparam int DOUBLE_REG_BUS_W = 64;

    typedef logic [1:0] div_state_t;

    typedef struct packed {
        logic is_signed;
        logic dividend_neg;
        logic divisor_neg;
    } div_sign_t;

endpackage

// File: rtl/divider_div_step.sv
// One restoring-division iteration: shift {rem, quo} left and keep the trial subtraction
// only when it does not go negative.
module divider_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W-1:0] wr_i,
    input  logic [DATA_W-1:0]   divisor_i,
    output logic [2*DATA_W-1:0] wr_o
);

    logic [2*DATA_W:0] shifted;
    logic [DATA_W:0]   trial;

    // The shifted remainder can carry one extra bit, so the trial runs on DATA_W+1 bits.
    assign shifted = {wr_i, 1'b0};
    assign trial   = shifted[2*DATA_W:DATA_W] - {1'b0, divisor_i};

    assign wr_o = trial[DATA_W] ? shifted[2*DATA_W-1:0]
                                : {trial[DATA_W-1:0], shifted[DATA_W-1:1], 1'b1};

endmodule

// File: rtl/divider.sv
// 32-bit radix-2 restoring divider for DIV/DIVU; returns {remainder, quotient} after 33 edges.
// Optional macro DIVIDER_EARLY_TERM_EN short-cuts divides whose |dividend| < |divisor|.
module divider
    import divider_pkg::*;
#(
    parameter int DATA_W = DOUBLE_REG_BUS_W / 2,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    div_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] wr_q, wr_d;
    logic [DATA_W-1:0]   divisor_q, divisor_d;
    div_sign_t           sign_q, sign_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    logic [DATA_W-1:0]   mag1, mag2;
    logic [2*DATA_W-1:0] step_wr;
    logic [DATA_W-1:0]   quo_fix, rem_fix;

    assign mag1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign mag2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    divider_div_step #(.DATA_W(DATA_W)) u_step (
        .wr_i      (wr_q),
        .divisor_i (divisor_q),
        .wr_o      (step_wr)
    );

    assign quo_fix = (sign_q.is_signed && (sign_q.dividend_neg ^ sign_q.divisor_neg))
                   ? -wr_q[DATA_W-1:0] : wr_q[DATA_W-1:0];
    assign rem_fix = (sign_q.is_signed && sign_q.dividend_neg)
                   ? -wr_q[2*DATA_W-1:DATA_W] : wr_q[2*DATA_W-1:DATA_W];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        divisor_d = divisor_q;
        sign_d    = sign_q;
        result_d  = result_q;
        ready_d   = ready_q;

        case (state_q)
            DIV_FREE: begin
                result_d = '0;
                ready_d  = DIV_RESULT_NOT_READY;
                if (start_i == DIV_START && !annul_i) begin
                    sign_d.is_signed    = signed_div_i;
                    sign_d.dividend_neg = opdata1_i[DATA_W-1];
                    sign_d.divisor_neg  = opdata2_i[DATA_W-1];
                    divisor_d           = mag2;
                    cnt_d               = '0;
                    // Divide-by-zero and the early bypass both pass through DIV_BY_ZERO,
                    // which forwards the preloaded working register untouched.
                    if (opdata2_i == '0) begin
                        state_d = DIV_BY_ZERO;
                        wr_d    = '0;
                    end
`ifdef DIVIDER_EARLY_TERM_EN
                    else if (mag1 < mag2) begin
                        state_d = DIV_BY_ZERO;
                        wr_d    = {mag1, {DATA_W{1'b0}}};
                    end
`endif
                    else begin
                        state_d = DIV_ON;
                        wr_d    = {{DATA_W{1'b0}}, mag1};
                    end
                end
            end

            DIV_BY_ZERO: begin
                state_d = DIV_END;
            end

            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else begin
                    wr_d  = step_wr;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = DIV_END;
                    end
                end
            end

            DIV_END: begin
                if (start_i == DIV_START) begin
                    result_d = {rem_fix, quo_fix};
                    ready_d  = DIV_RESULT_READY;
                end else begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                end
            end

            default: begin
                state_d = DIV_FREE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q   <= DIV_FREE;
            cnt_q     <= '0;
            wr_q      <= '0;
            divisor_q <= '0;
            sign_q    <= '0;
            result_q  <= '0;
            ready_q   <= DIV_RESULT_NOT_READY;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            divisor_q <= divisor_d;
            sign_q    <= sign_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_divider.sv
// Directed bench for the divider: scoreboard of expected {rem, quo}, latency checks,
// annul / start-drop / asynchronous-reset scenarios.
module tb_divider;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1, op2;
    logic        start, annul;
    logic [63:0] result;
    logic        ready;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];

`ifdef DIVIDER_EARLY_TERM_EN
    localparam int ET_LAT = 2;
`else
    localparam int ET_LAT = 33;
`endif

    divider dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_div(input string tag, input logic sg, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int lat);
        int n;
        logic seen;
        logic [63:0] want;
        sb_q.push_back(exp);
        @(negedge clk);
        signed_div = sg; op1 = a; op2 = b; start = 1'b1;
        @(posedge clk);
        #2 op1 = $urandom; op2 = $urandom; signed_div = ~sg;
        n = 0; seen = 1'b0;
        while (!seen && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (ready) seen = 1'b1;
        end
        chk({tag, "_latency"}, 64'(n), 64'(lat));
        want = sb_q.pop_front();
        chk({tag, "_result"}, result, want);
        @(negedge clk);
        chk({tag, "_held"}, 64'(ready), 64'd1);
        start = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_drop_ready"}, 64'(ready), 64'd0);
        chk({tag, "_drop_result"}, result, 64'd0);
        $display("div %s a=%h b=%h signed=%0d -> %h after %0d edges", tag, a, b, sg, want, n);
    endtask

    initial begin
        int n;
        logic seen;
        rst = 1'b1; signed_div = 1'b0; op1 = '0; op2 = '0; start = 1'b0; annul = 1'b0;
        #1;
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_result", result, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        run_div("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
        run_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33);
        run_div("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
        run_div("u5_0", 1'b0, 32'd5, 32'd0, 64'h0, 2);
        run_div("s_m5_0", 1'b1, 32'hFFFFFFFB, 32'd0, 64'h0, 2);
        run_div("s100_m7", 1'b1, 32'd100, 32'hFFFFFFF9, 64'h00000002_FFFFFFF2, 33);
        run_div("s_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 33);
        run_div("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 33);
        run_div("u_8h_max", 1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, ET_LAT);
        run_div("u3_10", 1'b0, 32'd3, 32'd10, 64'h00000003_00000000, ET_LAT);

        // Annul at iteration 10: no ready, back to idle, next divide unaffected.
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk) annul = 1'b1;
        @(posedge clk); #1;
        chk("annul_state", 64'(dut.state_q), 64'd0);
        @(negedge clk) begin annul = 1'b0; start = 1'b0; end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready) seen = 1'b1;
        end
        chk("annul_no_ready", 64'(seen), 64'd0);
        $display("annul during divide 1000/3 at iteration 10");
        run_div("u9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

        // start dropped mid-divide: completes silently and returns to idle.
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd12; op2 = 32'd4; start = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk) start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready) seen = 1'b1;
        end
        chk("drop_no_ready", 64'(seen), 64'd0);
        chk("drop_state", 64'(dut.state_q), 64'd0);
        $display("start dropped during divide 12/4");

        // Asynchronous reset mid-divide, between edges.
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        @(posedge clk);
        repeat (15) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_mid_ready", 64'(ready), 64'd0);
        chk("rst_mid_state", 64'(dut.state_q), 64'd0);
        start = 1'b0;
        #1 rst = 1'b0;

        // Asynchronous reset while a result is presented.
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        @(posedge clk);
        n = 0; seen = 1'b0;
        while (!seen && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (ready) seen = 1'b1;
        end
        chk("pre_rst_result", result, 64'h00000002_0000000E);
        #2 rst = 1'b1;
        #1;
        chk("rst_end_ready", 64'(ready), 64'd0);
        chk("rst_end_result", result, 64'd0);
        start = 1'b0;
        #1 rst = 1'b0;
        $display("async reset during divide and during result hold");
        run_div("u100_7_post_rst", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Multi-cycle 32-bit radix-2 restoring divider that sits beside the execute stage and serves DIV/DIVU.
- Execute drives the operands, the signed flag and a start request, and holds its stall request until the divider reports ready.
- The divider returns {remainder, quotient}, which execute forwards to HI/LO.
- One sub-unit; no pipelining of multiple divides.

Parameters:
- DATA_W, 32, operand width; result width is 2*DATA_W.
- CNT_W, 6, iteration counter width; must hold DATA_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset (`RstEnable).
- signed_div_i  in  1  1 = signed divide (DIV), 0 = unsigned (DIVU).
- opdata1_i  in  DATA_W  dividend.
- opdata2_i  in  DATA_W  divisor.
- start_i  in  1  `DivStart / `DivStop request from execute.
- annul_i  in  1  abort the in-flight divide (flush or branch cancel).
- result_o  out  2*DATA_W  {remainder[63:32], quotient[31:0]}.
- ready_o  out  1  `DivResultReady / `DivResultNotReady.

Behaviour:
- Reset (async, any state):
  - state = DivFree, cnt = 0.
  - result_o = 0, ready_o = `DivResultNotReady.
  - Any in-flight divide is discarded.
- All outputs are registered.
- FSM, 2-bit state:
  - DivFree:
    - start_i=1 and annul_i=0 and opdata2_i==0 -> DivByZero.
    - start_i=1 and annul_i=0 and divisor nonzero -> DivOn. Latch the magnitudes (negate an operand if signed_div_i=1 and its MSB=1), latch signed_div_i, both operand signs and the operands; cnt = 0; working register {rem=0, quo=|dividend|}.
    - Otherwise stay in DivFree.
  - DivByZero: next edge -> DivEnd with result 0.
  - DivOn:
    - If annul_i=1 -> DivFree immediately; ready_o stays 0.
    - Else, each cycle: shift {rem,quo} left by 1; trial = rem - |divisor| (DATA_W+1 bits). If trial is non-negative, rem = trial and quo LSB = 1; else quo LSB = 0. cnt++.
    - When cnt reaches DATA_W-1 and that step completes -> DivEnd.
  - DivEnd:
    - Sign fixup: quotient negated if signed and the latched signs differ. Remainder negated if signed and the latched dividend MSB = 1.
    - result_o = {rem, quo}; ready_o = 1, held while start_i=1.
    - When start_i=0 -> DivFree next edge; ready_o=0 and result_o=0 on that edge.
- Latency: start sampled at edge k -> ready_o high after edge k+33 (1 load cycle + 32 iterations). Divide-by-zero -> ready after edge k+2.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000 (wraps), remainder 0; no trap.
- annul_i in DivByZero or DivEnd: ignored. Termination there is governed by start_i only.
- start_i dropped mid-DivOn without annul_i: divide runs to completion, enters DivEnd, and returns to DivFree one edge later. No stale ready_o is presented to a new request.
- Operand inputs are ignored after the load cycle; they may change freely.

Optional Feature:
- Macro: DIVIDER_EARLY_TERM_EN.
- Defined: in DivFree, if the divisor is nonzero and |dividend| < |divisor| (magnitudes after signed negation), go directly to DivEnd with quo=0 and rem=|dividend|; the normal sign fixup applies. Latency is 2 edges, like divide-by-zero.
- Undefined: this case takes the full 33-edge path. Results are identical either way.

Decomposition:
- Shared defines include:
  - DivFree/DivByZero/DivOn/DivEnd 2-bit encodings.
  - `DivResultReady/`DivResultNotReady.
  - `DivStart/`DivStop.
  - `RstEnable.
  - `DoubleRegBus.
- One natural combinational sub-module, div_step: one shift-and-trial-subtract iteration.
  - Inputs: {rem,quo}, divisor.
  - Output: next {rem,quo}.
  - Instantiated once in DivOn.

Test Plan:
- Unsigned 100/7, start held -> ready_o rises after edge k+33; result_o = 64'h00000002_0000000E. Drop start -> ready_o=0 and result_o=0 next edge.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> result_o = 64'hFFFFFFFF_FFFFFFFD.
- Signed 0x80000000/0xFFFFFFFF -> 64'h00000000_80000000. Unsigned 5/0 -> ready after k+2, result_o = 0.
- annul_i pulsed at iteration 10 -> ready_o never rises; state returns to DivFree. A new start the next cycle with 9/3 yields 64'h00000000_00000003 after 33 edges.
- Async rst asserted mid-divide between clock edges -> ready_o=0 and result_o=0 immediately. After release, a fresh 100/7 completes correctly.
- DIVIDER_EARLY_TERM_EN: unsigned 3/10 -> result_o = 64'h00000003_00000000, ready after 2 edges when defined and after 33 edges when undefined.
